// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes I/S/B/U/J immediates from a 32-bit instruction
// and presents them through a registered valid/ready stage with an optional skid buffer.
module imm_gen_pipe #(
    parameter int XLEN = 64,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_data,
    output logic [2:0]      imm_fmt,
    output logic            imm_illegal
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    logic [6:0]  opcode;
    logic        isShift;
    logic [63:0] immI, immS, immB, immU, immJ;
    logic [63:0] dec64;
    fmt_e        decFmt;
    logic        decIll;
    entry_t      decoded;

    assign opcode  = inst[6:0];
    assign isShift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);

    // All formats are built at 64 bits and truncated, so XLEN=32 needs no special casing.
    assign immI = {{52{inst[31]}}, inst[31:20]};
    assign immS = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign immB = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign immU = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign immJ = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec64  = '0;
        decFmt = FMT_ILL;
        decIll = 1'b1;
        case (opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec64  = immI;
                decFmt = FMT_I;
                decIll = 1'b0;
            end
            OP_IMM: begin
                if (!isShift) begin
                    dec64  = immI;
                    decFmt = FMT_I;
                    decIll = 1'b0;
                end else if (RV64) begin
                    dec64  = {58'b0, inst[25:20]};
                    decFmt = FMT_I;
                    decIll = 1'b0;
                end else if (!inst[25]) begin
                    dec64  = {59'b0, inst[24:20]};
                    decFmt = FMT_I;
                    decIll = 1'b0;
                end
            end
            OP_IMM32: begin
                if (RV64) begin
                    dec64  = isShift ? {59'b0, inst[24:20]} : immI;
                    decFmt = FMT_I;
                    decIll = 1'b0;
                end
            end
            OP_STORE: begin
                dec64  = immS;
                decFmt = FMT_S;
                decIll = 1'b0;
            end
            OP_BRANCH: begin
                dec64  = immB;
                decFmt = FMT_B;
                decIll = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                dec64  = immU;
                decFmt = FMT_U;
                decIll = 1'b0;
            end
            OP_JAL: begin
                dec64  = immJ;
                decFmt = FMT_J;
                decIll = 1'b0;
            end
            OP_OP: begin
                decFmt = FMT_R;
                decIll = 1'b0;
            end
            OP_OP32: begin
                if (RV64) begin
                    decFmt = FMT_R;
                    decIll = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign decoded = {dec64[XLEN-1:0], decFmt, decIll};

    logic   mainValid_q, mainValid_d;
    logic   skidValid_q, skidValid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   accept, drain;

    assign in_ready = SKID ? !skidValid_q : (!mainValid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = mainValid_q && out_ready;

    // The skid register only fills while the main register is stalled, and it
    // always empties into the main register first so ordering is preserved.
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        main_d      = main_q;
        skid_d      = skid_q;
        if (SKID) begin
            if (!mainValid_q || drain) begin
                if (skidValid_q) begin
                    main_d      = skid_q;
                    mainValid_d = 1'b1;
                    skidValid_d = 1'b0;
                end else if (accept) begin
                    main_d      = decoded;
                    mainValid_d = 1'b1;
                end else begin
                    mainValid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d      = decoded;
                skidValid_d = 1'b1;
            end
        end else begin
            skidValid_d = 1'b0;
            if (accept) begin
                main_d      = decoded;
                mainValid_d = 1'b1;
            end else if (drain) begin
                mainValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    assign out_valid   = mainValid_q;
    assign imm_data    = main_q.data;
    assign imm_fmt     = main_q.fmt;
    assign imm_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=64/SKID=1 and one XLEN=32/SKID=0 instance,
// each with its own driver, queue of expected entries and monitor.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit done [2];

    logic [6:0]  opPool [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
    logic [31:0] dirInst [6] = '{32'h12345037, 32'hFE000EE3, 32'hFE113C23,
                                 32'h0000007F, 32'h0010009B, 32'h03F09093};
    exp_t dirExp64 [6] = '{
        {64'h0000000012345000, 3'd4, 1'b0},
        {64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0},
        {64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0},
        {64'h0, 3'd7, 1'b1},
        {64'h1, 3'd1, 1'b0},
        {64'd63, 3'd1, 1'b0}};
    exp_t dirExp32 [6] = '{
        {64'h0000000012345000, 3'd4, 1'b0},
        {64'h00000000FFFFFFFC, 3'd3, 1'b0},
        {64'h00000000FFFFFFF8, 3'd2, 1'b0},
        {64'h0, 3'd7, 1'b1},
        {64'h0, 3'd7, 1'b1},
        {64'h0, 3'd7, 1'b1}};

    // Reference decode: immediates computed as signed arithmetic on the encoded fields.
    function automatic exp_t refModel(input logic [31:0] ins, input int xlen);
        exp_t   e;
        longint v;
        longint s;
        bit     rv64;
        bit     sh;
        rv64  = (xlen == 64);
        sh    = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
        s     = ins[31] ? 64'sd1 : 64'sd0;
        v     = 0;
        e.fmt = 3'd7;
        case (ins[6:0])
            7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1;
                v = longint'(ins[31:20]) - s * 4096;
            end
            7'h13: begin
                if (!sh) begin
                    e.fmt = 3'd1;
                    v = longint'(ins[31:20]) - s * 4096;
                end else if (rv64) begin
                    e.fmt = 3'd1;
                    v = longint'(ins[25:20]);
                end else if (ins[25] == 1'b0) begin
                    e.fmt = 3'd1;
                    v = longint'(ins[24:20]);
                end
            end
            7'h1B: begin
                if (rv64) begin
                    e.fmt = 3'd1;
                    v = sh ? longint'(ins[24:20]) : longint'(ins[31:20]) - s * 4096;
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = longint'(ins[11:7]) + longint'(ins[31:25]) * 32 - s * 4096;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
                    + longint'(ins[7]) * 2048 - s * 4096;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096 - s * 64'sh100000000;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
                    + longint'(ins[19:12]) * 4096 - s * 1048576;
            end
            7'h33: e.fmt = 3'd0;
            7'h3B: if (rv64) e.fmt = 3'd0;
            default: ;
        endcase
        e.ill  = (e.fmt == 3'd7);
        e.data = rv64 ? 64'(v) : {32'b0, v[31:0]};
        return e;
    endfunction

    function automatic logic [31:0] randInst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opPool[$urandom_range(0, 11)];
        if ((w[6:0] == 7'h13 || w[6:0] == 7'h1B) && $urandom_range(0, 1) == 1)
            w[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int XL = (g == 0) ? 64 : 32;
        localparam bit SK = (g == 0);

        logic          reset_n;
        logic          in_valid;
        logic          in_ready;
        logic [31:0]   inst;
        logic          out_valid;
        logic          out_ready;
        logic [XL-1:0] imm_data;
        logic [2:0]    imm_fmt;
        logic          imm_illegal;

        exp_t expQ [$];
        int   readyMode;

        imm_gen_pipe #(.XLEN(XL), .SKID(SK)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .inst       (inst),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .imm_data   (imm_data),
            .imm_fmt    (imm_fmt),
            .imm_illegal(imm_illegal)
        );

        task automatic applyStimulus(input logic [31:0] w, input bit valid, input exp_t e,
                                     output bit accepted);
            @(negedge clk);
            in_valid = valid;
            inst     = w;
            #2;
            accepted = in_valid && in_ready;
            if (accepted) expQ.push_back(e);
        endtask

        task automatic checkOutput();
            bit expValid;
            bit expReady;
            exp_t e;
            expValid = (expQ.size() != 0);
            expReady = SK ? (expQ.size() < 2) : (expQ.size() == 0 || out_ready);
            vectors++;
            if (out_valid !== expValid) begin
                miscompares++;
                $display("[TB] FAIL out_valid dut%0d t=%0t: got %0b expected %0b",
                         g, $time, out_valid, expValid);
            end
            vectors++;
            if (in_ready !== expReady) begin
                miscompares++;
                $display("[TB] FAIL in_ready dut%0d t=%0t: got %0b expected %0b",
                         g, $time, in_ready, expReady);
            end
            if (out_valid && expQ.size() != 0) begin
                e = expQ[0];
                vectors++;
                if (64'(imm_data) !== e.data || imm_fmt !== e.fmt || imm_illegal !== e.ill) begin
                    miscompares++;
                    $display("[TB] FAIL payload dut%0d t=%0t: got %h/%0d/%0b expected %h/%0d/%0b",
                             g, $time, 64'(imm_data), imm_fmt, imm_illegal, e.data, e.fmt, e.ill);
                end
                if (out_ready) void'(expQ.pop_front());
            end
        endtask

        task automatic checkReset(input string tag);
            vectors++;
            if (out_valid !== 1'b0 || 64'(imm_data) !== 64'd0 || imm_fmt !== 3'd0 ||
                imm_illegal !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL %s dut%0d: got v=%0b d=%h f=%0d i=%0b rdy=%0b expected 0/0/0/0/1",
                         tag, g, out_valid, 64'(imm_data), imm_fmt, imm_illegal, in_ready);
            end
        endtask

        // Consumer side: drives out_ready per the selected pattern, then checks.
        initial begin
            out_ready = 1'b1;
            forever begin
                @(negedge clk);
                case (readyMode)
                    0: out_ready = ($urandom_range(0, 2) != 0);
                    2: out_ready = 1'b0;
                    3: out_ready = ~out_ready;
                    default: out_ready = 1'b1;
                endcase
                #1;
                if (reset_n) checkOutput();
            end
        end

        initial begin
            bit          acc;
            int          tries;
            logic [31:0] w;
            reset_n   = 1'b1;
            in_valid  = 1'b0;
            inst      = '0;
            readyMode = 1;
            #1 reset_n = 1'b0;
            #2 checkReset("reset_state");
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;

            for (int i = 0; i < 6; i++) begin
                tries = 0;
                acc   = 1'b0;
                while (!acc && tries < 20) begin
                    applyStimulus(dirInst[i], 1'b1, (XL == 64) ? dirExp64[i] : dirExp32[i], acc);
                    tries++;
                end
                if (!acc) begin
                    miscompares++;
                    $display("[TB] FAIL directed_accept dut%0d idx %0d: got no accept, expected accept", g, i);
                end
            end
            applyStimulus(32'h0, 1'b0, '0, acc);

            readyMode = 2;
            for (int i = 0; i < 4; i++) begin
                w = randInst();
                applyStimulus(w, 1'b1, refModel(w, XL), acc);
            end
            applyStimulus(32'h0, 1'b0, '0, acc);
            readyMode = 1;
            for (int i = 0; i < 6; i++) begin
                w = randInst();
                applyStimulus(w, 1'b1, refModel(w, XL), acc);
            end

            readyMode = 3;
            for (int i = 0; i < 40; i++) begin
                w = randInst();
                applyStimulus(w, 1'b1, refModel(w, XL), acc);
            end

            readyMode = 0;
            for (int i = 0; i < 1500; i++) begin
                w = randInst();
                applyStimulus(w, ($urandom_range(0, 3) != 0), refModel(w, XL), acc);
            end

            readyMode = 2;
            for (int i = 0; i < 4; i++) begin
                w = randInst();
                applyStimulus(w, 1'b1, refModel(w, XL), acc);
            end
            in_valid = 1'b0;
            #1 reset_n = 1'b0;
            #1 checkReset("reset_midop");
            expQ.delete();
            readyMode = 1;
            @(negedge clk);
            reset_n = 1'b1;
            for (int i = 0; i < 8; i++) begin
                w = randInst();
                applyStimulus(w, 1'b1, refModel(w, XL), acc);
            end

            applyStimulus(32'h0, 1'b0, '0, acc);
            tries = 0;
            while (expQ.size() != 0 && tries < 20) begin
                @(negedge clk);
                tries++;
            end
            vectors++;
            if (expQ.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL drain dut%0d: got %0d entries pending, expected 0", g, expQ.size());
            end
            done[g] = 1'b1;
        end
    end

    initial begin
        int cycles;
        cycles = 0;
        while (!(done[0] && done[1]) && cycles < 20000) begin
            @(posedge clk);
            cycles++;
        end
        if (!(done[0] && done[1])) begin
            miscompares++;
            $display("[TB] FAIL timeout: got done=%0b%0b, expected 11", done[1], done[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
